rv32i_run_ctrl: RTL and testbench
=================================

Name: rv32i_run_ctrl

Overview:
- Parametrised execution controller for the single-cycle rv32i core. Replaces the fixed-duration free-running simulation harness.
- Drives a clock-enable into the core and supports free-run, cycle-limited and single-step execution.
- Halts on NUM_BP PC breakpoints, ECALL or EBREAK.
- Keeps cycle and retired-instruction counters, readable by benches and by a future debug bridge.

Parameters:
- XLEN, 32, width of pc, instr and breakpoint addresses
- NUM_BP, 4, number of breakpoint comparator channels (1..16)
- CNT_W, 32, width of cycle_count, instret_count and max_cycles

Ports:
- clk_RV  in  1  core clock
- rst_n_RV  in  1  asynchronous active-low reset
- start  in  1  pulse: IDLE->RUN (counters cleared) or HALT->RUN (counters kept)
- step  in  1  pulse: from IDLE/HALT execute exactly one instruction
- stop  in  1  pulse: force halt from RUN
- clear  in  1  pulse: any state->IDLE, counters zeroed
- max_cycles  in  CNT_W  cycle budget; 0 = unlimited
- bp_addr  in  NUM_BP*XLEN  flattened breakpoint addresses, channel k at [k*XLEN +: XLEN]
- bp_en  in  NUM_BP  per-channel enable
- pc  in  XLEN  current core PC
- instr  in  32  instruction at pc
- cpu_en  out  1  core clock-enable; core state updates only when 1
- running  out  1  state is RUN or STEP
- halted  out  1  state is HALT
- halt_cause  out  3  0 none, 1 stop, 2 step, 3 breakpoint, 4 ecall, 5 ebreak, 6 cycle limit
- bp_id  out  4  index of the breakpoint channel that hit (lowest index wins)
- cycle_count  out  CNT_W  cycles with cpu_en=1
- instret_count  out  CNT_W  retired instructions, equal to cycle_count for a single-cycle core

Behaviour:
- Reset (async, rst_n_RV=0):
  - state IDLE; all outputs 0; skip_bp flag 0.
  - Takes effect mid-run, immediately deasserting cpu_en.
- States: IDLE, RUN, STEP, HALT.
- cpu_en is combinational:
  - In RUN: 1 unless a halt condition holds this cycle. An instruction that trips a halt is NOT executed: the core stops with pc pointing at it.
  - In STEP: always 1.
  - In IDLE and HALT: 0.
- Halt conditions in RUN, evaluated every cycle. Priority when several hold: stop > cycle limit > ebreak > ecall > breakpoint.
  - stop=1.
  - Cycle limit: max_cycles!=0 && cycle_count==max_cycles.
  - EBREAK: instr==32'h00100073.
  - ECALL: instr==32'h00000073.
  - Breakpoint: any bp_en[k] && pc==bp_addr[k], and skip_bp==0.
  - On any of these: next state HALT; halt_cause and bp_id registered.
- Transitions:
  - IDLE: start -> RUN with counters cleared and halt_cause=0. step -> STEP. start wins over step.
  - HALT: start -> RUN with skip_bp=1, so a resume steps off the current breakpoint. skip_bp clears after one RUN cycle. step -> STEP.
  - STEP: one cycle with cpu_en=1, ignoring breakpoints, ECALL and EBREAK. Next state HALT with cause 2.
  - Any state: clear -> IDLE. clear has the highest priority over start, step and stop.
  - start or step while in RUN: ignored. stop outside RUN: ignored.
- Counters:
  - Increment on every cycle with cpu_en=1.
  - Saturate at all-ones with no wrap.
  - A limit reached by a step does not halt the step; it halts the next RUN at its first cycle.
- running and halted are registered decodes of state.

Decomposition:
- Shared include rv32i_dbg_defs.vh holds the state encodings, the halt_cause codes (3-bit), and the ECALL/EBREAK instruction constants.
- Sub-module rv32i_bp_match, parametrised by NUM_BP and XLEN:
  - Combinational comparator bank with priority encoder.
  - Outputs hit and id.

Test Plan:
- Free-run with limit: max_cycles=10, start -> cpu_en high for exactly 10 cycles, then halted=1, halt_cause=6, cycle_count=10.
- Breakpoint and resume: bp_en=4'b0010, bp_addr[1]=0x20, pc advances by 4 from 0 -> halt with pc=0x20 not executed, cause 3, bp_id=1. start -> pc passes 0x20 without re-halting.
- Single step: from HALT, three step pulses -> three cycles with cpu_en=1, cycle_count +3, halt_cause=2 after each.
- ECALL vs breakpoint collision: instr=0x00000073 at pc=bp_addr[0] -> cause 4, cpu_en=0 that cycle.
- stop and clear: stop in RUN -> HALT, cause 1. Then clear together with start -> IDLE, counters 0.
- Reset mid-run: rst_n_RV low for 3 ns mid-cycle -> cpu_en=0 immediately, all outputs 0, state IDLE after release.

Source files
------------

// File: rtl/rv32i_run_ctrl_pkg.sv
// Shared types and constants for the rv32i run controller: FSM states, halt causes and
// the SYSTEM instruction encodings that stop a run.
package rv32i_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStep,
    StHalt
  } run_state_e;

  typedef enum logic [2:0] {
    CauseNone   = 3'd0,
    CauseStop   = 3'd1,
    CauseStep   = 3'd2,
    CauseBp     = 3'd3,
    CauseEcall  = 3'd4,
    CauseEbreak = 3'd5,
    CauseLimit  = 3'd6
  } halt_cause_e;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  // Resolves simultaneous halt requests: stop > limit > ebreak > ecall > breakpoint.
  function automatic halt_cause_e pick_cause(input logic stop, input logic limit,
                                             input logic ebreak, input logic ecall,
                                             input logic bp);
    halt_cause_e cause;
    cause = CauseNone;
    if (stop) begin
      cause = CauseStop;
    end else if (limit) begin
      cause = CauseLimit;
    end else if (ebreak) begin
      cause = CauseEbreak;
    end else if (ecall) begin
      cause = CauseEcall;
    end else if (bp) begin
      cause = CauseBp;
    end
    return cause;
  endfunction

endpackage

// File: rtl/rv32i_run_ctrl_if.sv
// Command, core-observation and status bundle between a bench/debug host (master) and the
// run controller (slave).
interface rv32i_run_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned CNT_W  = 32
) ();

  logic                     start;
  logic                     step;
  logic                     stop;
  logic                     clear;
  logic [CNT_W-1:0]         max_cycles;
  logic [NUM_BP*XLEN-1:0]   bp_addr;
  logic [NUM_BP-1:0]        bp_en;
  logic [XLEN-1:0]          pc;
  logic [31:0]              instr;

  logic                     cpu_en;
  logic                     running;
  logic                     halted;
  logic [2:0]               halt_cause;
  logic [3:0]               bp_id;
  logic [CNT_W-1:0]         cycle_count;
  logic [CNT_W-1:0]         instret_count;

  modport master (
    output start, step, stop, clear, max_cycles, bp_addr, bp_en, pc, instr,
    input  cpu_en, running, halted, halt_cause, bp_id, cycle_count, instret_count
  );

  modport slave (
    input  start, step, stop, clear, max_cycles, bp_addr, bp_en, pc, instr,
    output cpu_en, running, halted, halt_cause, bp_id, cycle_count, instret_count
  );

endinterface

// File: rtl/rv32i_bp_match.sv
// PC breakpoint comparator bank; reports whether any enabled channel matches and the
// lowest matching channel index.
module rv32i_bp_match #(
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned XLEN   = 32
) (
  input  logic [NUM_BP*XLEN-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [XLEN-1:0]        pc,
  output logic                   hit,
  output logic [3:0]             id
);

  always_comb begin
    hit = 1'b0;
    id  = 4'd0;
    // Scan high to low so the lowest matching channel is the one left standing.
    for (int k = int'(NUM_BP) - 1; k >= 0; k--) begin
      if (bp_en[k] && (pc == bp_addr[k*XLEN +: XLEN])) begin
        hit = 1'b1;
        id  = 4'(k);
      end
    end
  end

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Execution controller for the single-cycle rv32i core: gates the core clock-enable for
// free-run, cycle-limited and single-step execution, halting on breakpoints/ECALL/EBREAK.
module rv32i_run_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned CNT_W  = 32
) (
  input logic              clk_RV,
  input logic              rst_n_RV,
  rv32i_run_ctrl_if.slave  bus
);

  import rv32i_run_ctrl_pkg::*;

  run_state_e       state_q;
  halt_cause_e      cause_q;
  halt_cause_e      cause_sel;
  logic [3:0]       bp_id_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] instret_inc;
  logic             skip_bp_q;
  logic             running_q;
  logic             halted_q;

  logic             bp_hit;
  logic [3:0]       bp_hit_id;
  logic             limit_hit;
  logic             is_ecall;
  logic             is_ebreak;
  logic             run_halt;
  logic             cpu_en;

  rv32i_bp_match #(
    .NUM_BP (NUM_BP),
    .XLEN   (XLEN)
  ) u_bp_match (
    .bp_addr (bus.bp_addr),
    .bp_en   (bus.bp_en),
    .pc      (bus.pc),
    .hit     (bp_hit),
    .id      (bp_hit_id)
  );

  always_comb begin
    is_ecall  = (bus.instr == InstrEcall);
    is_ebreak = (bus.instr == InstrEbreak);
    limit_hit = (bus.max_cycles != '0) && (cycle_q == bus.max_cycles);
    cause_sel = pick_cause(bus.stop, limit_hit, is_ebreak, is_ecall, bp_hit && !skip_bp_q);
    run_halt  = (cause_sel != CauseNone);
    // A halting instruction is never executed: the core stays parked on it.
    cpu_en    = (state_q == StStep) || ((state_q == StRun) && !run_halt);
    cycle_inc   = (cycle_q == '1)   ? cycle_q   : cycle_q + CNT_W'(1);
    instret_inc = (instret_q == '1) ? instret_q : instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk_RV or negedge rst_n_RV) begin
    if (!rst_n_RV) begin
      state_q   <= StIdle;
      cause_q   <= CauseNone;
      bp_id_q   <= 4'd0;
      cycle_q   <= '0;
      instret_q <= '0;
      skip_bp_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else if (bus.clear) begin
      state_q   <= StIdle;
      cause_q   <= CauseNone;
      bp_id_q   <= 4'd0;
      cycle_q   <= '0;
      instret_q <= '0;
      skip_bp_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      if (cpu_en) begin
        cycle_q   <= cycle_inc;
        instret_q <= instret_inc;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StRun;
            cause_q   <= CauseNone;
            cycle_q   <= '0;
            instret_q <= '0;
            skip_bp_q <= 1'b0;
            running_q <= 1'b1;
          end else if (bus.step) begin
            state_q   <= StStep;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          skip_bp_q <= 1'b0;
          if (run_halt) begin
            state_q   <= StHalt;
            cause_q   <= cause_sel;
            bp_id_q   <= (cause_sel == CauseBp) ? bp_hit_id : 4'd0;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end
        end
        StStep: begin
          state_q   <= StHalt;
          cause_q   <= CauseStep;
          running_q <= 1'b0;
          halted_q  <= 1'b1;
        end
        StHalt: begin
          // Resuming sets skip_bp so the breakpoint we are parked on does not re-fire.
          if (bus.start) begin
            state_q   <= StRun;
            skip_bp_q <= 1'b1;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end else if (bus.step) begin
            state_q   <= StStep;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_en        = cpu_en;
  assign bus.running       = running_q;
  assign bus.halted        = halted_q;
  assign bus.halt_cause    = cause_q;
  assign bus.bp_id         = bp_id_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.instret_count = instret_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Randomised and directed bench for rv32i_run_ctrl against a behavioural run/halt model.
module tb_rv32i_run_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NUM_BP = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int CNT_MAX = 255;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk_RV   = 1'b0;
  logic rst_n_RV = 1'b0;
  always #5 clk_RV = ~clk_RV;

  rv32i_run_ctrl_if #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) bus ();

  rv32i_run_ctrl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
    .clk_RV   (clk_RV),
    .rst_n_RV (rst_n_RV),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;
  int en_seen = 0;
  logic [31:0] prog [64];

  // Model: mode 0 idle, 1 running, 2 single step, 3 halted.
  int m_mode, m_cause, m_bpid, m_cnt;
  bit m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int bp_first();
    for (int k = 0; k < int'(NUM_BP); k++)
      if (bus.bp_en[k] && bus.pc == bus.bp_addr[k*32 +: 32]) return k;
    return -1;
  endfunction

  function automatic int m_halt_reason();
    if (m_mode != 1) return 0;
    if (bus.stop) return 1;
    if (bus.max_cycles != 0 && m_cnt == int'(bus.max_cycles)) return 6;
    if (bus.instr == EBREAK) return 5;
    if (bus.instr == ECALL) return 4;
    if (!m_skip && bp_first() >= 0) return 3;
    return 0;
  endfunction

  function automatic bit m_cpu_en();
    return (m_mode == 2) || (m_mode == 1 && m_halt_reason() == 0);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cause = 0; m_bpid = 0; m_cnt = 0; m_skip = 0;
  endtask

  task automatic set_pc(input logic [31:0] a);
    bus.pc    = a & 32'hFC;
    bus.instr = prog[a[7:2]];
  endtask

  task automatic compare_all();
    check("cpu_en", 32'(bus.cpu_en), 32'(m_cpu_en()));
    check("running", 32'(bus.running), 32'(m_mode == 1 || m_mode == 2));
    check("halted", 32'(bus.halted), 32'(m_mode == 3));
    check("cycle_count", 32'(bus.cycle_count), m_cnt);
    check("instret_count", 32'(bus.instret_count), m_cnt);
    if (m_mode == 0 || m_mode == 3) check("halt_cause", 32'(bus.halt_cause), m_cause);
    if (m_mode == 3 && m_cause == 3) check("bp_id", 32'(bus.bp_id), m_bpid);
    if (bus.cpu_en) en_seen++;
  endtask

  // Called at a negedge: drive pulses, compare, advance model across the posedge.
  task automatic tick(input bit st, input bit sp, input bit so, input bit cl);
    bit en;
    int why;
    bus.start = st; bus.step = sp; bus.stop = so; bus.clear = cl;
    #1 compare_all();
    @(posedge clk_RV);
    en  = m_cpu_en();
    why = m_halt_reason();
    if (cl) begin
      m_reset();
    end else begin
      if (en && m_cnt < CNT_MAX) m_cnt++;
      case (m_mode)
        0: if (st) begin m_mode = 1; m_cnt = 0; m_cause = 0; m_skip = 0; end
           else if (sp) m_mode = 2;
        1: begin
             if (why != 0) begin
               m_mode = 3; m_cause = why; m_bpid = (why == 3) ? bp_first() : 0;
             end
             m_skip = 0;
           end
        2: begin m_mode = 3; m_cause = 2; end
        default: if (st) begin m_mode = 1; m_skip = 1; end
                 else if (sp) m_mode = 2;
      endcase
    end
    #1 if (en) set_pc(bus.pc + 4);
    @(negedge clk_RV);
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = NOP;
    bus.start = 0; bus.step = 0; bus.stop = 0; bus.clear = 0;
    bus.max_cycles = '0; bus.bp_addr = '0; bus.bp_en = '0;
    set_pc(0);
    m_reset();
    @(negedge clk_RV);
    check("reset cpu_en", 32'(bus.cpu_en), 0);
    check("reset counters", 32'(bus.cycle_count), 0);
    rst_n_RV = 1'b1;

    // Cycle-limited free run.
    bus.max_cycles = 8'd10;
    en_seen = 0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) idle_tick();
    check("limit en cycles", en_seen, 10);
    check("limit halted", 32'(bus.halted), 1);
    check("limit cause", 32'(bus.halt_cause), 6);
    check("limit count", 32'(bus.cycle_count), 10);

    // Breakpoint on channel 1, resume, stop, three single steps.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    bus.max_cycles = '0;
    bus.bp_addr[1*32 +: 32] = 32'h20;
    bus.bp_en = 4'b0010;
    set_pc(0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !bus.halted; i++) idle_tick();
    check("bp halted", 32'(bus.halted), 1);
    check("bp cause", 32'(bus.halt_cause), 3);
    check("bp id", 32'(bus.bp_id), 1);
    check("bp count", 32'(bus.cycle_count), 8);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle_tick();
    check("resume running", 32'(bus.running), 1);
    check("resume count", 32'(bus.cycle_count), 13);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("stop cause", 32'(bus.halt_cause), 1);
    for (int s = 0; s < 3; s++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      idle_tick();
      check("step cause", 32'(bus.halt_cause), 2);
    end
    check("step count", 32'(bus.cycle_count), 16);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("clear idle", 32'(bus.running | bus.halted), 0);
    check("clear count", 32'(bus.cycle_count), 0);

    // ECALL sitting on an enabled breakpoint address.
    prog[4] = ECALL;
    bus.bp_addr[0 +: 32] = 32'h10;
    bus.bp_en = 4'b0001;
    set_pc(0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !bus.halted; i++) idle_tick();
    check("ecall cause", 32'(bus.halt_cause), 4);
    check("ecall count", 32'(bus.cycle_count), 4);
    prog[4] = NOP;

    // Limit reached by stepping halts the following run immediately.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    bus.bp_en = '0;
    bus.max_cycles = 8'd2;
    for (int s = 0; s < 2; s++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      idle_tick();
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    idle_tick();
    check("step limit cause", 32'(bus.halt_cause), 6);
    check("step limit count", 32'(bus.cycle_count), 2);

    // Counter saturation.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    bus.max_cycles = '0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 270; i++) idle_tick();
    check("saturate", 32'(bus.cycle_count), 255);

    // Asynchronous reset in the middle of a run.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_tick();
    #1 rst_n_RV = 1'b0;
    #1;
    check("rst cpu_en", 32'(bus.cpu_en), 0);
    check("rst outputs", 32'({bus.running, bus.halted, bus.halt_cause, bus.bp_id}), 0);
    check("rst count", 32'(bus.cycle_count | bus.instret_count), 0);
    #2 rst_n_RV = 1'b1;
    m_reset();
    set_pc(0);
    @(negedge clk_RV);

    // Randomised phase.
    for (int i = 0; i < 64; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      prog[i] = (r < 6) ? ECALL : (r < 9) ? EBREAK : NOP;
    end
    set_pc(0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        bus.max_cycles = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 40)) : 8'd0;
        bus.bp_en = 4'($urandom_range(0, 15));
        for (int k = 0; k < int'(NUM_BP); k++)
          bus.bp_addr[k*32 +: 32] = 32'($urandom_range(0, 63) * 4);
      end
      tick($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
